// File: rtl/ls_mem_ctrl.sv
// ls_mem_ctrl: MEM-stage load/store bus controller, one outstanding access at a time.
//   clk_in, reset_in                  clock and synchronous active-high reset
//   req_valid/req_rdy, req_is_st,     load/store request from the MEM stage
//   ls_addr, st_data, size, mis, zero_ext
//   rsp_valid/rsp_rdy, rsp_ld_data,   response to the MEM->WB path
//   rsp_mis, rsp_fault
//   mem_req, mem_rw, mem_addr,        data-bus request, held until mem_ack
//   mem_wr_data, mem_be
//   mem_ack, mem_err, mem_rd_data     data-bus completion
module ls_mem_ctrl #(
    parameter int PC_SZ   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             req_valid,
    output logic             req_rdy,
    input  logic             req_is_st,
    input  logic [PC_SZ-1:0] ls_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       size,
    input  logic             mis,
    input  logic             zero_ext,
    output logic             rsp_valid,
    input  logic             rsp_rdy,
    output logic [31:0]      rsp_ld_data,
    output logic             rsp_mis,
    output logic             rsp_fault,
    output logic             mem_req,
    output logic             mem_rw,
    output logic [PC_SZ-1:0] mem_addr,
    output logic [31:0]      mem_wr_data,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic             mem_err,
    input  logic [31:0]      mem_rd_data
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic          is_st, zx;
    logic [1:0]    sz, sz_n;
    logic [1:0]    off;
    logic [3:0]    be_n;
    logic [31:0]   wr_n, sh, ld_ext;
    logic          timeout;

    // sz encoding: 0 = byte, 1 = half, 2 = word (any unrecognised size is a word)
    always_comb begin
        sz_n    = size == 3'd1 ? 2'd0 : size == 3'd2 ? 2'd1 : 2'd2;
        be_n    = sz_n == 2'd0 ? 4'b0001 << ls_addr[1:0] :
                  sz_n == 2'd1 ? 4'b0011 << ls_addr[1:0] : 4'b1111;
        wr_n    = sz_n == 2'd0 ? {4{st_data[7:0]}} :
                  sz_n == 2'd1 ? {2{st_data[15:0]}} : st_data;
        sh      = mem_rd_data >> {off, 3'b000};
        ld_ext  = sz == 2'd0 ? {{24{~zx & sh[7]}}, sh[7:0]} :
                  sz == 2'd1 ? {{16{~zx & sh[15]}}, sh[15:0]} : sh;
        timeout = timer == TW'(TIMEOUT - 1);
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? (mis ? RESP : BUS) : IDLE;
            BUS:     state_n = (mem_ack || timeout) ? RESP : BUS;
            RESP:    state_n = rsp_rdy ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they change with it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state       <= IDLE;
            timer       <= '0;
            req_rdy     <= 1'b1;
            mem_req     <= 1'b0;
            rsp_valid   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_be      <= '0;
            rsp_ld_data <= '0;
            rsp_mis     <= 1'b0;
            rsp_fault   <= 1'b0;
            is_st       <= 1'b0;
            zx          <= 1'b0;
            sz          <= '0;
            off         <= '0;
        end else begin
            state     <= state_n;
            req_rdy   <= state_n == IDLE;
            mem_req   <= state_n == BUS;
            rsp_valid <= state_n == RESP;
            timer     <= state == BUS ? timer + 1'b1 : '0;
            if (state == IDLE && req_valid) begin
                rsp_mis     <= mis;
                rsp_fault   <= 1'b0;
                rsp_ld_data <= '0;
                is_st       <= req_is_st;
                zx          <= zero_ext;
                sz          <= sz_n;
                off         <= ls_addr[1:0];
                if (!mis) begin
                    mem_rw      <= req_is_st;
                    mem_addr    <= {ls_addr[PC_SZ-1:2], 2'b00};
                    mem_be      <= be_n;
                    mem_wr_data <= wr_n;
                end
            end
            // An ack in the final timer cycle still wins over the timeout.
            if (state == BUS && mem_ack) begin
                rsp_fault   <= mem_err;
                rsp_ld_data <= (mem_err || is_st) ? '0 : ld_ext;
            end else if (state == BUS && timeout) begin
                rsp_fault <= 1'b1;
            end
        end
    end
endmodule
